// File: rtl/switch_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_input_pkg
//  Description : Shared constants for the switch input stage: processor word
//                width, switch data field width and default debounce length.
//  Revision    : 1.0 - initial release
// ============================================================================
package switch_input_pkg;

    // Processor word width; must track the system-wide word length.
    localparam int c_word_length = 32;

    // Board switches SW[16:0] carry data, SW[17] is the commit switch.
    localparam int c_data_width = 17;

    // 10 ms of stability at 50 MHz.
    localparam int c_debounce_cycles = 500000;

    // Counter width able to hold c_debounce_cycles - 1.
    localparam int c_cnt_width = 20;

endpackage : switch_input_pkg
`default_nettype wire

// File: rtl/switch_input_if.sv
`default_nettype none
// ============================================================================
//  Module      : switch_input_if
//  Description : Processor-side read handshake of the switch input stage.
//                req    - one-cycle read request from the processor
//                busy   - read in progress
//                valid  - one-cycle pulse, data_out holds the captured value
//                data_out - captured switch data, zero-extended
//                preview  - live switch data while waiting for a press
//  Revision    : 1.0 - initial release
// ============================================================================
interface switch_input_if
    import switch_input_pkg::*;
#(
    parameter int WORD_WIDTH = c_word_length
);

    logic                  req;
    logic                  busy;
    logic                  valid;
    logic [WORD_WIDTH-1:0] data_out;
    logic [WORD_WIDTH-1:0] preview;

    // Processor side
    modport master (
        output req,
        input  busy,
        input  valid,
        input  data_out,
        input  preview
    );

    // Switch input stage side
    modport slave (
        input  req,
        output busy,
        output valid,
        output data_out,
        output preview
    );

endinterface : switch_input_if
`default_nettype wire

// File: rtl/switch_input_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : switch_input_debounce
//  Description : Single-bit debouncer. The output follows the input only
//                after the input has disagreed with it for DEBOUNCE_CYCLES
//                consecutive cycles. The input must already be synchronous.
//                Ports: clock, reset (async, active-high), in, out.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_input_debounce
    import switch_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles,
    parameter int CNT_WIDTH       = c_cnt_width
) (
    input  wire  clock,
    input  wire  reset,
    input  wire  in,
    output logic out
);

    localparam logic [CNT_WIDTH-1:0] c_last_count = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 r_out;
    logic [CNT_WIDTH-1:0] r_cnt;

    // The counter only runs while the input disagrees with the debounced
    // level, so any agreeing cycle restarts the stability window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out <= 1'b0;
            r_cnt <= '0;
        end else if (in == r_out) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last_count) begin
            r_out <= ~r_out;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out = r_out;

endmodule : switch_input_debounce
`default_nettype wire

// File: rtl/switch_input.sv
`default_nettype none
// ============================================================================
//  Module      : switch_input
//  Description : Input stage behind the processor's switch-address reads.
//                Synchronises the board switches, debounces the commit
//                switch and, on request, captures the data field on the next
//                fresh commit press, reporting it after the release.
//                Ports: clock, reset (async, active-high),
//                       sw_in[DATA_WIDTH:0] raw switches (MSB = commit),
//                       bus (slave): req / busy / valid / data_out / preview.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_input
    import switch_input_pkg::*;
#(
    parameter int DATA_WIDTH      = c_data_width,
    parameter int WORD_WIDTH      = c_word_length,
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles,
    parameter int CNT_WIDTH       = c_cnt_width
) (
    input  wire                  clock,
    input  wire                  reset,
    input  wire [DATA_WIDTH:0]   sw_in,
    switch_input_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_PRE_RELEASE = 2'd1,
        S_ARMED       = 2'd2,
        S_HELD        = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic [WORD_WIDTH-1:0] r_data_out;
    logic [WORD_WIDTH-1:0] w_data_out_nxt;

    logic [DATA_WIDTH:0]   r_sync_meta;
    logic [DATA_WIDTH:0]   r_sw_s;
    logic                  w_commit_db;
    logic [WORD_WIDTH-1:0] w_sw_data_ext;

    // Two-flop synchroniser on every switch bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync_meta <= '0;
            r_sw_s      <= '0;
        end else begin
            r_sync_meta <= sw_in;
            r_sw_s      <= r_sync_meta;
        end
    end

    assign w_sw_data_ext = {{(WORD_WIDTH-DATA_WIDTH){1'b0}}, r_sw_s[DATA_WIDTH-1:0]};

    // Only the commit bit is debounced; data bits are sampled raw from the
    // synchronised bus at the capture edge.
    switch_input_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_commit_debounce (
        .clock (clock),
        .reset (reset),
        .in    (r_sw_s[DATA_WIDTH]),
        .out   (w_commit_db)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_valid    <= w_valid_nxt;
            r_data_out <= w_data_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_busy_nxt     = r_busy;
        w_valid_nxt    = 1'b0;
        w_data_out_nxt = r_data_out;
        case (r_state)
            S_IDLE: begin
                // A req coinciding with valid is dropped; the processor
                // re-issues it.
                if (bus.req && !r_valid) begin
                    w_busy_nxt = 1'b1;
                    // A press already held at req time must be released
                    // first so that only a fresh press is captured.
                    w_state_nxt = w_commit_db ? S_PRE_RELEASE : S_ARMED;
                end
            end
            S_PRE_RELEASE: begin
                if (!w_commit_db) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_commit_db) begin
                    w_data_out_nxt = w_sw_data_ext;
                    w_state_nxt    = S_HELD;
                end
            end
            S_HELD: begin
                if (!w_commit_db) begin
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = r_busy;
    assign bus.valid    = r_valid;
    assign bus.data_out = r_data_out;
    assign bus.preview  = (r_state == S_ARMED) ? w_sw_data_ext : '0;

endmodule : switch_input
`default_nettype wire

// File: tb/tb_switch_input.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_input
//  Description : Directed self-checking bench for switch_input with a short
//                debounce window. Expected capture values are queued when
//                the press is driven and compared when valid pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_input;
    import switch_input_pkg::*;

    localparam int DW = 17;
    localparam int WW = 32;
    localparam int DB = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW:0]   sw_in;

    switch_input_if #(.WORD_WIDTH(WW)) bus ();

    switch_input #(
        .DATA_WIDTH      (DW),
        .WORD_WIDTH      (WW),
        .DEBOUNCE_CYCLES (DB),
        .CNT_WIDTH       (20)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sw_in (sw_in),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int            n_vec   = 0;
    int            n_fail  = 0;
    int            n_valid = 0;
    logic [WW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any valid pulse there.
    task automatic tick();
        @(negedge clock);
        if (bus.valid === 1'b1) begin
            n_valid++;
            check("busy_low_in_valid", WW'(bus.busy), '0);
            if (exp_q.size() == 0)
                check("spurious_valid", WW'(bus.valid), '0);
            else
                check("data_out", bus.data_out, exp_q.pop_front());
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_req();
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max_ticks, input bit req_on_valid,
                              output int latency);
        int start;
        start   = n_valid;
        latency = 0;
        while (n_valid == start && latency < max_ticks) begin
            tick();
            latency++;
        end
        check({tag, "_valid_seen"}, WW'(n_valid - start), 1);
        if (req_on_valid && n_valid != start) begin
            bus.req = 1'b1;
            tick();
            bus.req = 1'b0;
            check("req_in_valid_cycle_busy", WW'(bus.busy), '0);
        end
    endtask

    // Assert reset between clock edges and check that outputs clear at once.
    task automatic async_reset_check(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, "_busy"},     WW'(bus.busy),  '0);
        check({tag, "_valid"},    WW'(bus.valid), '0);
        check({tag, "_data_out"}, bus.data_out,   '0);
        check({tag, "_preview"},  bus.preview,    '0);
    endtask

    task automatic release_reset();
        #2 reset = 1'b0;
    endtask

    initial begin
        int lat;
        int v0;

        reset   = 1'b1;
        sw_in   = '0;
        bus.req = 1'b0;
        ticks(3);
        reset = 1'b0;
        ticks(2);
        check("rst_busy",     WW'(bus.busy),  '0);
        check("rst_valid",    WW'(bus.valid), '0);
        check("rst_data_out", bus.data_out,   '0);
        check("rst_preview",  bus.preview,    '0);

        // Basic read
        v0 = n_valid;
        pulse_req();
        ticks(1);
        sw_in = {1'b0, 17'h1ABCD};
        ticks(4);
        check("basic_preview_armed", bus.preview, 32'h0001ABCD);
        check("basic_busy", WW'(bus.busy), 1);
        sw_in[DW] = 1'b1;
        exp_q.push_back(32'h0001ABCD);
        ticks(10);
        check("basic_preview_held", bus.preview, '0);
        check("basic_captured", bus.data_out, 32'h0001ABCD);
        sw_in[DW] = 1'b0;
        wait_valid("basic", 20, 1'b0, lat);
        check("basic_latency_ok", WW'(lat >= DB + 1 && lat <= DB + 3), 1);
        ticks(10);
        check("basic_one_valid", WW'(n_valid - v0), 1);

        // Reset while armed, commit held through reset release
        pulse_req();
        sw_in = 18'h3FFFF;
        ticks(4);
        check("rst_mid_preview_before", bus.preview, 32'h0001FFFF);
        async_reset_check("rst_mid");
        ticks(2);
        release_reset();
        v0 = n_valid;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("rst_after_busy", WW'(bus.busy), '0);
        end
        check("rst_after_no_valid", WW'(n_valid - v0), '0);
        sw_in = '0;
        ticks(10);

        // Bouncing commit while armed
        v0 = n_valid;
        pulse_req();
        sw_in = {1'b0, 17'h0F0F0};
        for (int i = 0; i < 10; i++) begin
            sw_in[DW] = (i % 2 == 0);
            ticks(2);
        end
        ticks(6);
        check("bounce_still_armed", bus.preview, 32'h0000F0F0);
        check("bounce_no_capture", bus.data_out, '0);
        sw_in[DW] = 1'b1;
        exp_q.push_back(32'h0000F0F0);
        ticks(10);
        sw_in[DW] = 1'b0;
        wait_valid("bounce", 20, 1'b0, lat);
        ticks(10);
        check("bounce_one_valid", WW'(n_valid - v0), 1);

        // Commit already held when req arrives
        v0 = n_valid;
        sw_in = {1'b1, 17'h00111};
        ticks(10);
        pulse_req();
        ticks(5);
        check("held_busy", WW'(bus.busy), 1);
        check("held_pre_release_preview", bus.preview, '0);
        sw_in = {1'b1, 17'h00222};
        ticks(5);
        sw_in = {1'b0, 17'h00333};
        ticks(8);
        check("held_armed_preview", bus.preview, 32'h00000333);
        sw_in = {1'b1, 17'h12345};
        exp_q.push_back(32'h00012345);
        ticks(10);
        sw_in[DW] = 1'b0;
        wait_valid("held", 20, 1'b0, lat);
        check("held_data_out", bus.data_out, 32'h00012345);
        ticks(5);
        check("held_one_valid", WW'(n_valid - v0), 1);

        // Extra req pulses while busy and in the valid cycle
        v0 = n_valid;
        pulse_req();
        sw_in = {1'b0, 17'h0AAAA};
        ticks(3);
        pulse_req();
        ticks(2);
        sw_in[DW] = 1'b1;
        exp_q.push_back(32'h0000AAAA);
        ticks(10);
        pulse_req();
        ticks(2);
        sw_in[DW] = 1'b0;
        wait_valid("ignore", 20, 1'b1, lat);
        ticks(10);
        check("ignore_busy_idle", WW'(bus.busy), '0);
        check("ignore_one_valid", WW'(n_valid - v0), 1);

        // Reset while holding a captured press
        pulse_req();
        sw_in = {1'b0, 17'h00055};
        ticks(3);
        sw_in[DW] = 1'b1;
        ticks(10);
        check("rst_held_captured", bus.data_out, 32'h00000055);
        check("rst_held_busy", WW'(bus.busy), 1);
        async_reset_check("rst_held");
        ticks(2);
        release_reset();
        ticks(10);
        sw_in[DW] = 1'b0;
        v0 = n_valid;
        ticks(20);
        check("rst_held_no_valid", WW'(n_valid - v0), '0);
        check("rst_held_data_out", bus.data_out, '0);

        check("scoreboard_drained", WW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_switch_input
`default_nettype wire
